// File: rtl/input_event_ctrl.sv
// rtl/input_event_ctrl.sv - button edge/long-press event generator with round-robin arbiter and 4-deep event FIFO
module input_event_ctrl #(
    parameter int TICK_DIV   = 65536,
    parameter int LONG_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_level,
    output logic       tick,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [4:0] ev_data,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam int              CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]      LONG_PRE  = 8'(LONG_TICKS - 1);

    typedef enum logic [1:0] {
        EV_PRESS   = 2'b00,
        EV_RELEASE = 2'b01,
        EV_LONG    = 2'b10
    } ev_type_e;

    logic [CW-1:0] tcnt_q;
    logic [4:0]    lvl_q, lvl_qq;
    logic [7:0]    hold_q [5];
    logic [4:0]    pend_press_q, pend_long_q, pend_rel_q;
    logic [4:0]    pend_press_d, pend_long_d, pend_rel_d;
    logic [2:0]    rr_q, rr_d;
    logic [4:0]    mem_q [4];
    logic [1:0]    wr_q, rd_q;
    logic [2:0]    cnt_q;
    logic          ovf_q, ovf_d;

    logic [4:0]    rise, fall, long_ev, any_pend;
    logic [4:0]    g_press, g_long, g_rel;
    logic          gnt_valid, full, pop, drop;
    logic [2:0]    gnt_id;
    ev_type_e      gnt_type;

    assign tick     = (tcnt_q == TICK_LAST);
    assign rise     = lvl_q & ~lvl_qq;
    assign fall     = ~lvl_q & lvl_qq;
    assign full     = (cnt_q == 3'd4);
    assign ev_valid = (cnt_q != 3'd0);
    assign pop      = ev_valid & ev_ready;
    assign ev_data  = ev_valid ? mem_q[rd_q] : 5'd0;
    assign overflow = ovf_q;
    assign any_pend = pend_press_q | pend_long_q | pend_rel_q;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            long_ev[i] = lvl_q[i] & tick & (hold_q[i] == LONG_PRE);
        end
    end

    // Round-robin search starting at rr_q; first button with anything pending wins.
    always_comb begin : arb
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = 3'd0;
        gnt_type  = EV_PRESS;
        g_press   = '0;
        g_long    = '0;
        g_rel     = '0;
        if (!full) begin
            for (int k = 0; k < 5; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= 5) idx = idx - 5;
                if (!gnt_valid && any_pend[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 3'(idx);
                    if (pend_press_q[idx]) begin
                        gnt_type     = EV_PRESS;
                        g_press[idx] = 1'b1;
                    end else if (pend_long_q[idx]) begin
                        gnt_type    = EV_LONG;
                        g_long[idx] = 1'b1;
                    end else begin
                        gnt_type   = EV_RELEASE;
                        g_rel[idx] = 1'b1;
                    end
                end
            end
        end
    end

    // A same-cycle grant and new event of one type leaves the flag set, so nothing is lost.
    always_comb begin
        pend_press_d = (pend_press_q & ~g_press) | rise;
        pend_long_d  = (pend_long_q  & ~g_long)  | long_ev;
        pend_rel_d   = (pend_rel_q   & ~g_rel)   | fall;
        drop         = |((rise    & pend_press_q & ~g_press) |
                         (long_ev & pend_long_q  & ~g_long)  |
                         (fall    & pend_rel_q   & ~g_rel));
        ovf_d        = drop | (ovf_q & ~clr_overflow);
        rr_d         = rr_q;
        if (gnt_valid) begin
            rr_d = (gnt_id == 3'd4) ? 3'd0 : gnt_id + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q       <= '0;
            lvl_q        <= '0;
            lvl_qq       <= '0;
            pend_press_q <= '0;
            pend_long_q  <= '0;
            pend_rel_q   <= '0;
            rr_q         <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < 5; i++) hold_q[i] <= '0;
        end else begin
            tcnt_q       <= tick ? '0 : tcnt_q + CW'(1);
            lvl_q        <= btn_level;
            lvl_qq       <= lvl_q;
            pend_press_q <= pend_press_d;
            pend_long_q  <= pend_long_d;
            pend_rel_q   <= pend_rel_d;
            rr_q         <= rr_d;
            ovf_q        <= ovf_d;
            if (gnt_valid) wr_q <= wr_q + 2'd1;
            if (pop)       rd_q <= rd_q + 2'd1;
            cnt_q        <= cnt_q + {2'b00, gnt_valid} - {2'b00, pop};
            for (int i = 0; i < 5; i++) begin
                if (!lvl_q[i]) begin
                    hold_q[i] <= '0;
                end else if (tick && hold_q[i] != 8'hFF) begin
                    hold_q[i] <= hold_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_valid) mem_q[wr_q] <= {gnt_type, gnt_id};
    end
endmodule

// File: tb/tb_input_event_ctrl.sv
// tb/tb_input_event_ctrl.sv - randomized and directed bench for input_event_ctrl against a queue-based model
module tb_input_event_ctrl;
    localparam int TD = 4;
    localparam int LT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_level = '0;
    logic       ev_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       tick, ev_valid, overflow;
    logic [4:0] ev_data;

    input_event_ctrl #(.TICK_DIV(TD), .LONG_TICKS(LT)) dut (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .tick(tick),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-button state as plain arrays, FIFO as a queue.
    int         m_tcnt;
    bit [4:0]   m_lvl, m_prev, m_pp, m_pl, m_pr;
    int         m_hold [5];
    int         m_rr;
    bit         m_ovf;
    logic [4:0] m_q [$];
    logic [4:0] got [$];

    always @(posedge clk or negedge rst_n) begin : mdl
        bit       t, do_pop;
        bit [4:0] rise, fall, lng, gp, gl, gr;
        int       gid, id;
        if (!rst_n) begin
            m_tcnt = 0; m_lvl = 0; m_prev = 0; m_pp = 0; m_pl = 0; m_pr = 0;
            m_rr = 0; m_ovf = 0; m_q.delete();
            for (int i = 0; i < 5; i++) m_hold[i] = 0;
        end else begin
            t      = (m_tcnt == TD - 1);
            do_pop = (m_q.size() > 0) && ev_ready;
            gid = -1; gp = 0; gl = 0; gr = 0;
            if (m_q.size() < 4) begin
                for (int k = 0; k < 5; k++) begin
                    id = (m_rr + k) % 5;
                    if (gid < 0 && (m_pp[id] || m_pl[id] || m_pr[id])) gid = id;
                end
            end
            for (int i = 0; i < 5; i++) begin
                rise[i] = m_lvl[i] && !m_prev[i];
                fall[i] = !m_lvl[i] && m_prev[i];
                lng[i]  = m_lvl[i] && t && (m_hold[i] == LT - 1);
            end
            if (do_pop) void'(m_q.pop_front());
            if (gid >= 0) begin
                if (m_pp[gid]) begin gp[gid] = 1; m_q.push_back({2'b00, 3'(gid)}); end
                else if (m_pl[gid]) begin gl[gid] = 1; m_q.push_back({2'b10, 3'(gid)}); end
                else begin gr[gid] = 1; m_q.push_back({2'b01, 3'(gid)}); end
                m_rr = (gid + 1) % 5;
            end
            if (((rise & m_pp & ~gp) | (lng & m_pl & ~gl) | (fall & m_pr & ~gr)) != 0) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            m_pp = (m_pp & ~gp) | rise;
            m_pl = (m_pl & ~gl) | lng;
            m_pr = (m_pr & ~gr) | fall;
            for (int i = 0; i < 5; i++) begin
                if (!m_lvl[i]) m_hold[i] = 0;
                else if (t && m_hold[i] < 255) m_hold[i] = m_hold[i] + 1;
            end
            m_prev = m_lvl;
            m_lvl  = btn_level;
            m_tcnt = (m_tcnt + 1) % TD;
        end
    end

    always @(negedge clk) begin
        chk("tick", int'(tick), int'(m_tcnt == TD - 1));
        chk("ev_valid", int'(ev_valid), int'(m_q.size() > 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (m_q.size() > 0) chk("ev_data", int'(ev_data), int'(m_q[0]));
        else if (!rst_n) chk("ev_data_rst", int'(ev_data), 0);
        if (rst_n && ev_valid && ev_ready) got.push_back(ev_data);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(int budget);
        bit idle;
        ev_ready = 1'b1;
        idle = 0;
        for (int c = 0; c < budget; c++) begin
            idle = (m_q.size() == 0) && (m_pp == 0) && (m_pl == 0) && (m_pr == 0) &&
                   (btn_level == m_lvl) && (m_lvl == m_prev);
            if (idle) break;
            step(1);
        end
        chk("drain_done", int'(idle), 1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_ev_valid"}, int'(ev_valid), 0);
        chk({tag, "_ev_data"}, int'(ev_data), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        logic [4:0] exp_a [2];
        logic [4:0] exp_b [3];
        logic [4:0] exp_c [5];
        exp_a = '{5'b00_010, 5'b01_010};
        exp_b = '{5'b00_001, 5'b10_001, 5'b01_001};
        exp_c = '{5'b00_011, 5'b00_100, 5'b00_000, 5'b00_001, 5'b00_010};

        step(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);

        // Single press: visible after the third edge, popped in one cycle.
        ev_ready = 1'b1;
        got.delete();
        btn_level = 5'b00100;
        step(2);
        chk("a_valid_edge2", int'(ev_valid), 0);
        step(1);
        chk("a_valid_edge3", int'(ev_valid), 1);
        chk("a_data_edge3", int'(ev_data), 5'b00_010);
        step(1);
        chk("a_valid_after_pop", int'(ev_valid), 0);
        step(2);
        btn_level = '0;
        drain(50);
        chk("a_count", got.size(), 2);
        for (int i = 0; i < 2; i++)
            if (got.size() > i) chk($sformatf("a_ev%0d", i), int'(got[i]), int'(exp_a[i]));

        // Long press on button 1.
        got.delete();
        btn_level = 5'b00010;
        step(20);
        btn_level = '0;
        drain(60);
        chk("b_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            if (got.size() > i) chk($sformatf("b_ev%0d", i), int'(got[i]), int'(exp_b[i]));

        // Two grants of button 2 leave the round-robin pointer at 3.
        btn_level = 5'b00100;
        step(4);
        btn_level = '0;
        drain(50);
        ev_ready = 1'b0;
        got.delete();
        btn_level = 5'b11111;
        step(8);
        chk("c_valid_full", int'(ev_valid), 1);
        chk("c_head_full", int'(ev_data), 5'b00_011);
        ev_ready = 1'b1;
        step(12);
        chk("c_enough", int'(got.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            if (got.size() > i) chk($sformatf("c_ev%0d", i), int'(got[i]), int'(exp_c[i]));
        btn_level = '0;
        drain(100);

        // Toggle button 0 into a stalled FIFO until a PRESS is dropped.
        ev_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_level[0] = 1'b1;
            step(2);
            btn_level[0] = 1'b0;
            step(2);
        end
        step(5);
        chk("d_overflow_set", int'(overflow), 1);
        step(5);
        chk("d_overflow_sticky", int'(overflow), 1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        chk("d_overflow_clr", int'(overflow), 0);
        drain(60);

        // Reset mid-operation with button 4 held.
        ev_ready = 1'b0;
        btn_level = 5'b10000;
        step(5);
        chk("e_valid_before", int'(ev_valid), 1);
        rst_n = 1'b0;
        step(1);
        chk_reset_outputs("e_rst");
        step(2);
        got.delete();
        ev_ready = 1'b1;
        rst_n = 1'b1;
        step(8);
        chk("e_count", got.size(), 1);
        if (got.size() > 0) chk("e_ev0", int'(got[0]), 5'b00_100);
        btn_level = '0;
        drain(60);

        // Random traffic with stall phases and occasional overflow clears.
        for (int ph = 0; ph < 10; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 95);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 5) == 0) btn_level[$urandom_range(0, 4)] ^= 1'b1;
                ev_ready     = ($urandom_range(0, 99) < rdy_pct);
                clr_overflow = ($urandom_range(0, 40) == 0);
                step(1);
            end
        end
        clr_overflow = 1'b0;
        btn_level = '0;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
